// File: rtl/alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : alu_dispatch
// Purpose  : RV32I decode/issue stage producing registered ALU operands, op
//            code and writeback control behind a valid/ready handshake.
//            Optional issue/illegal counters: define ALU_DISPATCH_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module alu_dispatch #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_operand1,
    output logic [XLEN-1:0] out_operand2,
    output logic [3:0]      out_operation,
    output logic [4:0]      out_rd,
    output logic            out_wb_en,
    output logic            out_illegal
`ifdef ALU_DISPATCH_STATS_EN
    ,
    output logic [31:0]     stat_issued,
    output logic [31:0]     stat_illegal
`endif
);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_SLT  = 4'd8;
    localparam logic [3:0] c_OP_SLTU = 4'd9;
    localparam logic [3:0] c_OP_OLUI = 4'd10;

    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] c_F7_ZERO   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic            w_legal;
    logic [3:0]      w_op;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_accept;

    logic            r_valid;
    logic [XLEN-1:0] r_operand1;
    logic [XLEN-1:0] r_operand2;
    logic [3:0]      r_operation;
    logic [4:0]      r_rd;
    logic            r_wb_en;
    logic            r_illegal;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign w_imm_u  = {in_instr[31:12], 12'b0};

    always_comb begin
        w_legal = 1'b0;
        w_op    = c_OP_ADD;
        w_op1   = '0;
        w_op2   = '0;
        case (w_opcode)
            c_OPC_OP: begin
                w_legal = 1'b1;
                w_op1   = in_rs1_val;
                w_op2   = in_rs2_val;
                if (w_funct7 == c_F7_ZERO) begin
                    case (w_funct3)
                        3'b000:  w_op = c_OP_ADD;
                        3'b001:  w_op = c_OP_SLL;
                        3'b010:  w_op = c_OP_SLT;
                        3'b011:  w_op = c_OP_SLTU;
                        3'b100:  w_op = c_OP_XOR;
                        3'b101:  w_op = c_OP_SRL;
                        3'b110:  w_op = c_OP_OR;
                        default: w_op = c_OP_AND;
                    endcase
                end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b000) begin
                    w_op = c_OP_SUB;
                end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b101) begin
                    w_op = c_OP_SRA;
                end else begin
                    w_legal = 1'b0;
                end
            end
            c_OPC_OPIMM: begin
                w_legal = 1'b1;
                w_op1   = in_rs1_val;
                w_op2   = w_imm_i;
                case (w_funct3)
                    3'b000:  w_op = c_OP_ADD;
                    3'b001: begin
                        w_op = c_OP_SLL;
                        if (w_funct7 != c_F7_ZERO) w_legal = 1'b0;
                    end
                    3'b010:  w_op = c_OP_SLT;
                    3'b011:  w_op = c_OP_SLTU;
                    3'b100:  w_op = c_OP_XOR;
                    3'b101: begin
                        if (w_funct7 == c_F7_ZERO)     w_op = c_OP_SRL;
                        else if (w_funct7 == c_F7_ALT) w_op = c_OP_SRA;
                        else                           w_legal = 1'b0;
                    end
                    3'b110:  w_op = c_OP_OR;
                    default: w_op = c_OP_AND;
                endcase
            end
            c_OPC_LUI: begin
                w_legal = 1'b1;
                w_op    = c_OP_OLUI;
                w_op2   = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_legal = 1'b1;
                w_op    = c_OP_ADD;
                w_op1   = in_pc;
                w_op2   = w_imm_u;
            end
            default: ;
        endcase
        // Trapped instructions still flow, but carry a neutral ALU request.
        if (!w_legal) begin
            w_op  = c_OP_ADD;
            w_op1 = '0;
            w_op2 = '0;
        end
    end

    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_operand1  <= '0;
            r_operand2  <= '0;
            r_operation <= '0;
            r_rd        <= '0;
            r_wb_en     <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_operand1  <= w_op1;
            r_operand2  <= w_op2;
            r_operation <= w_op;
            r_rd        <= in_instr[11:7];
            r_wb_en     <= w_legal && (in_instr[11:7] != 5'd0);
            r_illegal   <= !w_legal;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_operand1  = r_operand1;
    assign out_operand2  = r_operand2;
    assign out_operation = r_operation;
    assign out_rd        = r_rd;
    assign out_wb_en     = r_wb_en;
    assign out_illegal   = r_illegal;

`ifdef ALU_DISPATCH_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_illegal;

    // Counts output handshakes only; flushed instructions never reach here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_issued  <= '0;
            r_stat_illegal <= '0;
        end else if (r_valid && out_ready) begin
            if (r_illegal) r_stat_illegal <= r_stat_illegal + 32'd1;
            else           r_stat_issued  <= r_stat_issued + 32'd1;
        end
    end

    assign stat_issued  = r_stat_issued;
    assign stat_illegal = r_stat_illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_dispatch
// Purpose  : Directed self-checking bench for alu_dispatch with an expected-
//            result queue popped on every output handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_dispatch;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] o1;
        logic [31:0] o2;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_rs1_val = '0;
    logic [31:0] in_rs2_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_operand1;
    logic [31:0] out_operand2;
    logic [3:0]  out_operation;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_illegal;
`ifdef ALU_DISPATCH_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_illegal;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_iss = 0;
    int   n_ill = 0;
    exp_t sb[$];

    alu_dispatch #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_rs1_val   (in_rs1_val),
        .in_rs2_val   (in_rs2_val),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_operand1 (out_operand1),
        .out_operand2 (out_operand2),
        .out_operation(out_operation),
        .out_rd       (out_rd),
        .out_wb_en    (out_wb_en),
        .out_illegal  (out_illegal)
`ifdef ALU_DISPATCH_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_illegal (stat_illegal)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic [31:0] o1, input logic [31:0] o2,
                                input logic [4:0] rd, input logic wb, input logic ill);
        exp_t e;
        e.op = op; e.o1 = o1; e.o2 = o2; e.rd = rd; e.wb = wb; e.ill = ill;
        return e;
    endfunction

    // Drive one instruction, queue its expected result, and return once accepted.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input exp_t e);
        int   n;
        logic acc;
        in_instr   = ins;
        in_pc      = pc;
        in_rs1_val = r1;
        in_rs2_val = r2;
        in_valid   = 1'b1;
        sb.push_back(e);
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            exp_t e;
            chk("sb_has_entry", {31'd0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("operation", {28'd0, out_operation}, {28'd0, e.op});
                chk("operand1", out_operand1, e.o1);
                chk("operand2", out_operand2, e.o2);
                chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
                chk("wb_en", {31'd0, out_wb_en}, {31'd0, e.wb});
                chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                if (e.ill) n_ill++;
                else       n_iss++;
            end
        end
    end

    initial begin
        int c0;
        int n;

        // Reset held with a pending instruction must not leak through.
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_instr   = 32'h002081B3;
        in_rs1_val = 32'd5;
        in_rs2_val = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_operand1", out_operand1, 32'd0);
        chk("rst_operand2", out_operand2, 32'd0);
        chk("rst_misc", {20'd0, out_operation, out_rd, out_wb_en, out_illegal}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
        send(32'h40335293, 32'h0, 32'h80000000, 32'd0, mk(4'd7, 32'h80000000, 32'h00000403, 5'd5, 1'b1, 1'b0));
        send(32'hFFF00093, 32'h0, 32'd0, 32'd0, mk(4'd0, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0));
        send(32'h12345237, 32'h0, 32'd9, 32'd9, mk(4'd10, 32'd0, 32'h12345000, 5'd4, 1'b1, 1'b0));
        send(32'h00001217, 32'h100, 32'd9, 32'd9, mk(4'd0, 32'h100, 32'h1000, 5'd4, 1'b1, 1'b0));
        send(32'h402081B3, 32'h0, 32'd10, 32'd3, mk(4'd1, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0));
        send(32'h00208033, 32'h0, 32'd1, 32'd2, mk(4'd0, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;

        // Backpressure: held output must stay put and block new input.
        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'h11, 32'h22, mk(4'd0, 32'h11, 32'h22, 5'd3, 1'b1, 1'b0));
        in_instr   = 32'h0020C3B3;
        in_rs1_val = 32'hF0;
        in_rs2_val = 32'h0F;
        in_valid   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_operand1", out_operand1, 32'h11);
            chk("hold_operand2", out_operand2, 32'h22);
            chk("hold_rd", {27'd0, out_rd}, 32'd3);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        c0 = cyc;
        send(32'h0020C3B3, 32'h0, 32'hF0, 32'h0F, mk(4'd4, 32'hF0, 32'h0F, 5'd7, 1'b1, 1'b0));
        send(32'h0020B433, 32'h0, 32'h1, 32'h2, mk(4'd9, 32'h1, 32'h2, 5'd8, 1'b1, 1'b0));
        send(32'h0020D4B3, 32'h0, 32'h80, 32'h3, mk(4'd6, 32'h80, 32'h3, 5'd9, 1'b1, 1'b0));
        send(32'h0FF0F513, 32'h0, 32'h1234, 32'h0, mk(4'd2, 32'h1234, 32'hFF, 5'd10, 1'b1, 1'b0));
        chk("b2b_cycles", cyc - c0, 32'd4);
        @(posedge clk);
        #1;

        // Illegal instruction held, then discarded by flush.
        out_ready = 1'b0;
        send(32'h0000000F, 32'h0, 32'h55, 32'h66, mk(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
        void'(sb.pop_back());
        @(negedge clk);
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_illegal", {31'd0, out_illegal}, 32'd1);
        chk("ill_wb_en", {31'd0, out_wb_en}, 32'd0);
        chk("ill_operand1", out_operand1, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        send(32'h022081B3, 32'h0, 32'd4, 32'd5, mk(4'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1));
        send(32'h40111093, 32'h0, 32'd4, 32'd5, mk(4'd0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1));
        send(32'h00000001, 32'h0, 32'd4, 32'd5, mk(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        chk("out_valid_final", {31'd0, out_valid}, 32'd0);
`ifdef ALU_DISPATCH_STATS_EN
        chk("stat_issued", stat_issued, n_iss);
        chk("stat_illegal", stat_illegal, n_ill);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
